// File: rtl/nios1_onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port 4096x16 on-chip RAM between two
// Avalon-MM pipelined masters; one access per clock, fixed 1-cycle read latency.
module nios1_onchip_mem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata
);
   localparam int BE_W = DATA_W / 8;

   logic                w_req0;
   logic                w_req1;
   logic                w_grant;
   logic                w_win;
   logic                w_win_write;
   logic [ADDR_W-1:0]   w_addr;
   logic [BE_W-1:0]     w_be;
   logic [DATA_W-1:0]   w_wdata;

   logic                r_last_grant;
   logic                r_rd_pending;
   logic                r_rd_owner;
   logic [ADDR_W-1:0]   r_addr_hold;
   logic [BE_W-1:0]     r_be_hold;
   logic [DATA_W-1:0]   r_wdata_hold;

   // Under contention the master that did not win last time goes first.
   always_comb begin
      w_req0      = m0_read | m0_write;
      w_req1      = m1_read | m1_write;
      w_grant     = ~reset & (w_req0 | w_req1);
      w_win       = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
      w_win_write = w_win ? m1_write : m0_write;
      w_addr      = w_win ? m1_address : m0_address;
      w_wdata     = w_win ? m1_writedata : m0_writedata;
      w_be        = '1;
      if (w_win_write) begin
         w_be = w_win ? m1_byteenable : m0_byteenable;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant <= 1'b1;
         r_rd_pending <= 1'b0;
         r_rd_owner   <= 1'b0;
         r_addr_hold  <= '0;
         r_be_hold    <= '0;
         r_wdata_hold <= '0;
      end else begin
         r_rd_pending <= w_grant & ~w_win_write;
         if (w_grant) begin
            r_last_grant <= w_win;
            r_rd_owner   <= w_win;
            r_addr_hold  <= w_addr;
            r_be_hold    <= w_be;
            r_wdata_hold <= w_wdata;
         end
      end
   end

   assign m0_waitrequest   = ~(w_grant & ~w_win);
   assign m1_waitrequest   = ~(w_grant &  w_win);

   // Returned data is shared; only the valid strobe identifies the owner.
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = r_rd_pending & ~r_rd_owner;
   assign m1_readdatavalid = r_rd_pending &  r_rd_owner;

   assign mem_address      = w_grant ? w_addr  : r_addr_hold;
   assign mem_byteenable   = w_grant ? w_be    : r_be_hold;
   assign mem_writedata    = w_grant ? w_wdata : r_wdata_hold;
   assign mem_chipselect   = w_grant;
   assign mem_write        = w_grant & w_win_write;
   assign mem_clken        = ~reset;

endmodule

// File: tb/tb_nios1_onchip_mem_arbiter.sv
// Bench for nios1_onchip_mem_arbiter: behavioural RAM plus an array/round-robin
// reference model, directed scenarios followed by randomized two-master traffic.
module tb_nios1_onchip_mem_arbiter;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;
   localparam int BE_W   = 2;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [ADDR_W-1:0]   m0_address = '0;
   logic [BE_W-1:0]     m0_byteenable = '0;
   logic                m0_read = 1'b0;
   logic                m0_write = 1'b0;
   logic [DATA_W-1:0]   m0_writedata = '0;
   logic [ADDR_W-1:0]   m1_address = '0;
   logic [BE_W-1:0]     m1_byteenable = '0;
   logic                m1_read = 1'b0;
   logic                m1_write = 1'b0;
   logic [DATA_W-1:0]   m1_writedata = '0;
   logic                m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0]   m0_readdata, m1_readdata;
   logic                m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0]   mem_address;
   logic [BE_W-1:0]     mem_byteenable;
   logic                mem_chipselect, mem_write, mem_clken;
   logic [DATA_W-1:0]   mem_writedata;
   logic [DATA_W-1:0]   mem_readdata = '0;

   always #5 clk = ~clk;

   nios1_onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
   );

   // Single-port RAM with registered read data and byte-lane writes.
   logic [DATA_W-1:0] tb_ram [4096];
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         if (mem_write) begin
            if (mem_byteenable[0]) tb_ram[mem_address][7:0]  <= mem_writedata[7:0];
            if (mem_byteenable[1]) tb_ram[mem_address][15:8] <= mem_writedata[15:8];
         end
         mem_readdata <= tb_ram[mem_address];
      end
   end

   // Reference model state
   logic [DATA_W-1:0] ref_mem [4096];
   int                m_last  = 1;
   bit                m_pend  = 1'b0;
   int                m_owner = 0;
   logic [DATA_W-1:0] m_data  = '0;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] init_val(input int i);
      return 16'(i * 40503) ^ 16'h5A5A;
   endfunction

   // One clock: drive inputs after the edge, check against the model at negedge.
   task automatic do_cycle(input bit rst,
                           input bit r0, input bit w0, input logic [ADDR_W-1:0] a0,
                           input logic [BE_W-1:0] be0, input logic [DATA_W-1:0] d0,
                           input bit r1, input bit w1, input logic [ADDR_W-1:0] a1,
                           input logic [BE_W-1:0] be1, input logic [DATA_W-1:0] d1,
                           output bit acc0, output bit acc1);
      bit q0, q1, gv, wr;
      int win;
      logic [ADDR_W-1:0] addr;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wd;
      @(posedge clk);
      #1;
      reset = rst;
      m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
      m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
      @(negedge clk);
      q0 = r0 | w0;
      q1 = r1 | w1;
      check_eq("rdvalid0", 32'(m0_readdatavalid), 32'(m_pend && m_owner == 0));
      check_eq("rdvalid1", 32'(m1_readdatavalid), 32'(m_pend && m_owner == 1));
      if (m_pend) begin
         check_eq("rdata", 32'((m_owner == 0) ? m0_readdata : m1_readdata), 32'(m_data));
      end
      check_eq("clken", 32'(mem_clken), 32'(!rst));
      gv = !rst && (q0 || q1);
      if (!gv) win = -1;
      else if (q0 && q1) win = (m_last == 1) ? 0 : 1;
      else win = q0 ? 0 : 1;
      wr = (win == 0) ? w0 : ((win == 1) ? w1 : 1'b0);
      check_eq("wait0", 32'(m0_waitrequest), 32'(win != 0));
      check_eq("wait1", 32'(m1_waitrequest), 32'(win != 1));
      check_eq("chipselect", 32'(mem_chipselect), 32'(gv));
      check_eq("mem_write", 32'(mem_write), 32'(wr));
      if (gv) begin
         addr = (win == 0) ? a0 : a1;
         be   = (win == 0) ? be0 : be1;
         wd   = (win == 0) ? d0 : d1;
         check_eq("mem_address", 32'(mem_address), 32'(addr));
         if (wr) begin
            check_eq("mem_be_wr", 32'(mem_byteenable), 32'(be));
            check_eq("mem_wdata", 32'(mem_writedata), 32'(wd));
            if (be[0]) ref_mem[addr][7:0]  = wd[7:0];
            if (be[1]) ref_mem[addr][15:8] = wd[15:8];
         end else begin
            check_eq("mem_be_rd", 32'(mem_byteenable), 32'(2'b11));
            m_data = ref_mem[addr];
         end
      end
      if (rst) begin
         m_last = 1;
         m_pend = 1'b0;
      end else if (gv) begin
         m_last  = win;
         m_owner = win;
         m_pend  = !wr;
      end else begin
         m_pend = 1'b0;
      end
      acc0 = !m0_waitrequest;
      acc1 = !m1_waitrequest;
   endtask

   // Random traffic driver state
   bit                pr [2];
   bit                pw [2];
   logic [ADDR_W-1:0] pa [2];
   logic [BE_W-1:0]   pbe [2];
   logic [DATA_W-1:0] pd [2];
   bit                busy [2];

   task automatic new_op(input int n);
      int k;
      k      = $urandom_range(0, 9);
      pr[n]  = (k >= 3 && k <= 6) || k == 9;
      pw[n]  = (k >= 7);
      pa[n]  = 12'($urandom_range(0, 15));
      pbe[n] = 2'($urandom_range(0, 3));
      pd[n]  = 16'($urandom);
   endtask

   initial begin
      bit a0, a1;
      int i0, i1, prev, gw;
      for (int i = 0; i < 4096; i++) begin
         tb_ram[i]  = init_val(i);
         ref_mem[i] = init_val(i);
      end

      // Reset held with m0 reading: nothing accepted; m0 wins right after release
      for (int i = 0; i < 3; i++)
         do_cycle(1, 1, 0, 12'h005, 2'b00, 16'h0, 0, 0, 12'h0, 2'b00, 16'h0, a0, a1);
      do_cycle(0, 1, 0, 12'h005, 2'b00, 16'h0, 0, 0, 12'h0, 2'b00, 16'h0, a0, a1);
      check_eq("rst_first_grant", 32'(a0), 32'(1));
      do_cycle(0, 0, 0, 12'h0, 2'b00, 16'h0, 0, 0, 12'h0, 2'b00, 16'h0, a0, a1);

      // Single write then read-after-write
      do_cycle(0, 0, 1, 12'h123, 2'b11, 16'hBEEF, 0, 0, 12'h0, 2'b00, 16'h0, a0, a1);
      check_eq("wr_accept", 32'(a0), 32'(1));
      do_cycle(0, 1, 0, 12'h123, 2'b00, 16'h0, 0, 0, 12'h0, 2'b00, 16'h0, a0, a1);
      check_eq("rd_accept", 32'(a0), 32'(1));
      do_cycle(0, 0, 0, 12'h0, 2'b00, 16'h0, 0, 0, 12'h0, 2'b00, 16'h0, a0, a1);
      check_eq("beef_valid", 32'(m0_readdatavalid), 32'(1));
      check_eq("beef_data", 32'(m0_readdata), 32'(16'hBEEF));

      // Byte lanes on m1
      do_cycle(0, 0, 0, 12'h0, 2'b00, 16'h0, 0, 1, 12'h010, 2'b11, 16'h5555, a0, a1);
      do_cycle(0, 0, 0, 12'h0, 2'b00, 16'h0, 0, 1, 12'h010, 2'b01, 16'h00AA, a0, a1);
      do_cycle(0, 0, 0, 12'h0, 2'b00, 16'h0, 1, 0, 12'h010, 2'b00, 16'h0, a0, a1);
      do_cycle(0, 0, 0, 12'h0, 2'b00, 16'h0, 0, 0, 12'h0, 2'b00, 16'h0, a0, a1);
      check_eq("lane_valid", 32'(m1_readdatavalid), 32'(1));
      check_eq("lane_data", 32'(m1_readdata), 32'(16'h55AA));

      // Contention: 4 reads each, grants must alternate every cycle
      i0 = 0; i1 = 0; prev = -1;
      for (int c = 0; c < 20 && (i0 < 4 || i1 < 4); c++) begin
         do_cycle(0, i0 < 4, 0, 12'h200 + 12'(i0), 2'b00, 16'h0,
                  i1 < 4, 0, 12'h300 + 12'(i1), 2'b00, 16'h0, a0, a1);
         gw = a0 ? 0 : (a1 ? 1 : -1);
         check_eq("cont_one_grant", 32'(a0 ^ a1), 32'(1));
         if (prev >= 0) check_eq("cont_alternate", 32'(gw), 32'(1 - prev));
         prev = gw;
         if (a0) i0++;
         if (a1) i1++;
      end
      check_eq("cont_done", 32'(i0 + i1), 32'(8));
      do_cycle(0, 0, 0, 12'h0, 2'b00, 16'h0, 0, 0, 12'h0, 2'b00, 16'h0, a0, a1);

      // Read and write together is a write with no response
      do_cycle(0, 1, 1, 12'h020, 2'b11, 16'h1234, 0, 0, 12'h0, 2'b00, 16'h0, a0, a1);
      check_eq("rw_is_write", 32'(mem_write), 32'(1));
      do_cycle(0, 0, 0, 12'h0, 2'b00, 16'h0, 0, 0, 12'h0, 2'b00, 16'h0, a0, a1);
      check_eq("rw_no_valid", 32'(m0_readdatavalid), 32'(0));

      // Reset right after an m1 read accept: that read returns, reset-time read dropped
      do_cycle(0, 0, 0, 12'h0, 2'b00, 16'h0, 1, 0, 12'h300, 2'b00, 16'h0, a0, a1);
      do_cycle(1, 1, 0, 12'h301, 2'b00, 16'h0, 0, 0, 12'h0, 2'b00, 16'h0, a0, a1);
      check_eq("rst_inflight_valid", 32'(m1_readdatavalid), 32'(1));
      check_eq("rst_inflight_data", 32'(m1_readdata), 32'(init_val(12'h300)));
      do_cycle(0, 0, 0, 12'h0, 2'b00, 16'h0, 0, 0, 12'h0, 2'b00, 16'h0, a0, a1);
      check_eq("rst_drop_valid", 32'(m0_readdatavalid | m1_readdatavalid), 32'(0));

      // Randomized traffic with occasional resets; masters hold until accepted
      busy[0] = 1'b0;
      busy[1] = 1'b0;
      for (int c = 0; c < 600; c++) begin
         bit rst;
         rst = ($urandom_range(0, 59) == 0);
         for (int n = 0; n < 2; n++) if (!busy[n]) new_op(n);
         do_cycle(rst, pr[0], pw[0], pa[0], pbe[0], pd[0],
                  pr[1], pw[1], pa[1], pbe[1], pd[1], a0, a1);
         busy[0] = (pr[0] | pw[0]) && !a0;
         busy[1] = (pr[1] | pw[1]) && !a1;
      end
      do_cycle(0, 0, 0, 12'h0, 2'b00, 16'h0, 0, 0, 12'h0, 2'b00, 16'h0, a0, a1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/nios1_onchip_mem_arbiter.md
# nios1_onchip_mem_arbiter

Two-master arbiter that shares the single-port 4096×16 on-chip RAM between requesters, e.g. Nios II data master and a DMA. Each master sees an Avalon-MM pipelined slave with waitrequest and readdatavalid. The arbiter drives the RAM's address, byteenable, chipselect, write, writedata and clken pins. Round-robin grant, one access per cycle, fixed 1-cycle read latency.

## Interface
- ADDR_W, 12, word address width (4096 words)
- DATA_W, 16, data width; byteenable width BE_W = DATA_W/8
- clk  in  1  single clock for the arbiter and the RAM
- reset  in  1  reset is synchronous and active-high
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  BE_W  byte lanes for writes; ignored on reads
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  high = request not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data, qualified by readdatavalid
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid strobe
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken
- mem_readdata  in  DATA_W  from RAM; valid the cycle after the address is clocked

## Operation
- Request: reqN = mN_read | mN_write. If read and write are both high, the access is a write and the read is ignored.
- Grant logic is combinational each cycle:
  - Only one master requesting: that master wins.
  - Both requesting: the master not granted last wins.
  - Neither requesting: no grant.
- Accepted transfer: waitrequest of the winner is 0 in the same cycle. The loser's waitrequest is 1.
  - Idle master: waitrequest = 1.
  - Masters hold their request signals stable while waitrequest = 1.
- RAM drive:
  - When a grant exists: mem_address, mem_byteenable and mem_writedata come from the winner; mem_chipselect = 1; mem_write = winner write.
  - When no grant exists: mem_chipselect = 0 and mem_write = 0. Address, byteenable and writedata hold the last granted values; this is don't-care for the RAM.
- Reads force mem_byteenable = all ones.
- mem_clken = ~reset.
- last_grant register: updated to the winner on every grant and held when idle. Reset value = 1, so m0 wins the first contention.
- Read return tracking:
  - Registered rd_pending and rd_owner capture (grant & ~write) and the winner index each cycle.
  - mN_readdatavalid = rd_pending & (rd_owner == N).
  - mN_readdata = mem_readdata for both masters; it is qualified only by the valid strobe.
- Writes produce no response.

## Timing
- Reset values:
  - last_grant = 1, rd_pending = 0.
  - While reset is high: both waitrequests = 1, mem_chipselect = 0, mem_write = 0, mem_clken = 0.
  - Both readdatavalid = 0 in the cycle after any reset cycle.
- Throughput: one accepted transfer per clk. Back-to-back reads from either or both masters are fully pipelined.
- Read latency: a read accepted in cycle N gives readdatavalid = 1 with data in cycle N+1, exactly one cycle later, for the owner only.
- Write: takes effect at the clk edge ending the accept cycle. A read of the same address accepted in the next cycle returns the new data.
- Contention with both masters continuously requesting: grants alternate m0, m1, m0, …, so each master gets 50% and waits at most 1 cycle.
- Reset mid-operation:
  - A request present while reset is high is not accepted.
  - A read accepted in the cycle just before reset still returns; rd_pending was already set.
  - A read that would be accepted during reset is dropped, because rd_pending is cleared.
- rd_owner and the readdata path are valid only when rd_pending = 1.

## Test plan
- Reset: hold reset 3 cycles with m0_read = 1 -> m0_waitrequest = 1, mem_chipselect = 0, no readdatavalid. On the first cycle after release, m0 is granted.
- Single write/read: m0 writes 0xBEEF to 0x123 with be = 2'b11, then reads 0x123 -> one cycle of waitrequest = 0 each; m0_readdatavalid = 1 with 0xBEEF one cycle after the read accept.
- Byte lanes: m1 writes 0x00AA with be = 2'b01 to 0x010, which holds 0x5555 -> a read returns 0x55AA.
- Contention: both masters issue 4 reads each from distinct preloaded addresses -> grants alternate m0, m1, … across 8 consecutive cycles. Each readdatavalid appears only on its owner, with the correct data, one cycle after each accept.
- Read+write simultaneously: m0_read = m0_write = 1 -> mem_write = 1 and m0_readdatavalid stays 0.
- Reset during traffic: reset asserted in the cycle after an m1 read accept -> m1_readdatavalid = 1 in that reset cycle. A read requested during reset gets no valid.
